// File: rtl/instr_loader.sv
// Byte-stream program loader: parses a length-prefixed, XOR-checksummed image and
// writes the assembled instruction words into instruction memory while holding the core off.
module instr_loader #(
   parameter int unsigned width_in  = 12,
   parameter int unsigned width_out = 17,
   parameter int unsigned depth     = 2048
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 start,
   input  logic                 in_valid,
   input  logic [7:0]           in_data,
   output logic                 in_ready,
   output logic                 mem_wr_en,
   output logic [width_in-1:0]  mem_addr,
   output logic [width_out-1:0] mem_data,
   output logic                 busy,
   output logic                 done,
   output logic                 error,
   output logic [width_in:0]    words_loaded
);

   localparam int unsigned B    = (width_out + 7) / 8;
   localparam int unsigned IdxW = (B > 1) ? $clog2(B) : 1;
   localparam logic [IdxW-1:0] LastIdx = IdxW'(B - 1);

   localparam logic [2:0] StIdle  = 3'd0;
   localparam logic [2:0] StLenLo = 3'd1;
   localparam logic [2:0] StLenHi = 3'd2;
   localparam logic [2:0] StData  = 3'd3;
   localparam logic [2:0] StChk   = 3'd4;
   localparam logic [2:0] StDone  = 3'd5;
   localparam logic [2:0] StErr   = 3'd6;

   logic [2:0]           state_q, state_d;
   logic [15:0]          len_q, len_d;
   logic [7:0]           chk_q, chk_d;
   logic [IdxW-1:0]      idx_q, idx_d;
   logic [B*8-1:0]       word_q, word_d;
   logic [width_in:0]    words_q, words_d;
   logic                 wr_en_q, wr_en_d;
   logic [width_in-1:0]  wr_addr_q, wr_addr_d;
   logic [width_out-1:0] wr_data_q, wr_data_d;

   logic                 accept;
   logic [B*8-1:0]       word_full;
   logic [width_in:0]    words_inc;
   logic [15:0]          len_full;

   assign in_ready     = (state_q == StLenLo) || (state_q == StLenHi) ||
                         (state_q == StData)  || (state_q == StChk);
   assign busy         = in_ready;
   assign done         = (state_q == StDone);
   assign error        = (state_q == StErr);
   assign accept       = in_valid && in_ready;
   assign mem_wr_en    = wr_en_q;
   assign mem_addr     = wr_addr_q;
   assign mem_data     = wr_data_q;
   assign words_loaded = words_q;
   assign words_inc    = words_q + 1'b1;
   assign len_full     = {in_data, len_q[7:0]};

   // Current word with the incoming byte merged into its lane.
   always_comb begin
      word_full = word_q;
      for (int k = 0; k < int'(B); k++) begin
         if (idx_q == IdxW'(k)) begin
            word_full[8*k +: 8] = in_data;
         end
      end
   end

   always_comb begin
      state_d   = state_q;
      len_d     = len_q;
      chk_d     = chk_q;
      idx_d     = idx_q;
      word_d    = word_q;
      words_d   = words_q;
      wr_en_d   = 1'b0;
      wr_addr_d = wr_addr_q;
      wr_data_d = wr_data_q;
      case (state_q)
         StIdle, StDone, StErr: begin
            if (start) begin
               state_d = StLenLo;
               chk_d   = 8'h00;
               idx_d   = '0;
               words_d = '0;
            end
         end
         StLenLo: begin
            if (accept) begin
               len_d[7:0] = in_data;
               chk_d      = chk_q ^ in_data;
               state_d    = StLenHi;
            end
         end
         StLenHi: begin
            if (accept) begin
               len_d = len_full;
               chk_d = chk_q ^ in_data;
               if (32'(len_full) > depth) begin
                  state_d = StErr;
               end else if (len_full == 16'h0000) begin
                  state_d = StChk;
               end else begin
                  state_d = StData;
               end
            end
         end
         StData: begin
            if (accept) begin
               chk_d  = chk_q ^ in_data;
               word_d = word_full;
               if (idx_q == LastIdx) begin
                  idx_d     = '0;
                  wr_en_d   = 1'b1;
                  wr_addr_d = words_q[width_in-1:0];
                  wr_data_d = word_full[width_out-1:0];
                  words_d   = words_inc;
                  // Leaving on the final write lets CHK land while that strobe is high.
                  if (32'(words_inc) == 32'(len_q)) begin
                     state_d = StChk;
                  end
               end else begin
                  idx_d = idx_q + 1'b1;
               end
            end
         end
         StChk: begin
            if (accept) begin
               state_d = (in_data == chk_q) ? StDone : StErr;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= StIdle;
         len_q     <= '0;
         chk_q     <= '0;
         idx_q     <= '0;
         word_q    <= '0;
         words_q   <= '0;
         wr_en_q   <= 1'b0;
         wr_addr_q <= '0;
         wr_data_q <= '0;
      end else begin
         state_q   <= state_d;
         len_q     <= len_d;
         chk_q     <= chk_d;
         idx_q     <= idx_d;
         word_q    <= word_d;
         words_q   <= words_d;
         wr_en_q   <= wr_en_d;
         wr_addr_q <= wr_addr_d;
         wr_data_q <= wr_data_d;
      end
   end

endmodule

// File: tb/tb_instr_loader.sv
// Self-checking bench for instr_loader: directed frames plus random frames scored
// against a frame-parsing reference model.
module tb_instr_loader;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        start = 1'b0;
   logic        in_valid = 1'b0;
   logic [7:0]  in_data = 8'h00;
   logic        in_ready;
   logic        mem_wr_en;
   logic [11:0] mem_addr;
   logic [16:0] mem_data;
   logic        busy;
   logic        done;
   logic        error;
   logic [12:0] words_loaded;

   instr_loader #(
      .width_in  (12),
      .width_out (17),
      .depth     (2048)
   ) dut (
      .clk          (clk),
      .rst          (rst),
      .start        (start),
      .in_valid     (in_valid),
      .in_data      (in_data),
      .in_ready     (in_ready),
      .mem_wr_en    (mem_wr_en),
      .mem_addr     (mem_addr),
      .mem_data     (mem_data),
      .busy         (busy),
      .done         (done),
      .error        (error),
      .words_loaded (words_loaded)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [11:0] a;
      logic [16:0] d;
   } wr_t;

   int         checks = 0;
   int         failures = 0;
   logic [7:0] frame_q[$];
   wr_t        seen_q[$];

   always @(negedge clk) begin
      if (mem_wr_en === 1'b1) seen_q.push_back('{a: mem_addr, d: mem_data});
   end

   initial begin
      #3000000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic do_start();
      seen_q.delete();
      @(negedge clk);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      check("busy_after_start", busy, 1);
   endtask

   task automatic send_byte(input logic [7:0] b, input bit gap);
      int n = 0;
      if (gap) begin
         @(negedge clk);
         in_valid = 1'b0;
      end
      @(negedge clk);
      in_valid = 1'b1;
      in_data  = b;
      while (!in_ready && n < 8) begin
         @(negedge clk);
         n++;
      end
      check("in_ready_wait", in_ready, 1);
      @(posedge clk);
   endtask

   // Reference: parse frame_q as a whole image and compare end state and all writes.
   task automatic check_model(input string tag);
      int unsigned n;
      int unsigned exp_words;
      logic [7:0]  x;
      logic        exp_done;
      logic [16:0] d;
      n = {frame_q[1], frame_q[0]};
      if (n > 2048) begin
         exp_words = 0;
         exp_done  = 1'b0;
      end else begin
         exp_words = n;
         x = 8'h00;
         for (int i = 0; i < frame_q.size() - 1; i++) x ^= frame_q[i];
         exp_done = (frame_q[frame_q.size() - 1] == x);
      end
      check({tag, "_done"}, done, exp_done);
      check({tag, "_error"}, error, !exp_done);
      check({tag, "_busy"}, busy, 0);
      check({tag, "_in_ready"}, in_ready, 0);
      check({tag, "_words"}, words_loaded, exp_words);
      check({tag, "_nwrites"}, seen_q.size(), exp_words);
      for (int i = 0; i < int'(exp_words) && i < seen_q.size(); i++) begin
         d = {frame_q[4+3*i][0], frame_q[3+3*i], frame_q[2+3*i]};
         check({tag, "_addr"}, seen_q[i].a, i);
         check({tag, "_data"}, seen_q[i].d, d);
      end
   endtask

   // mode 0: back-to-back, 1: one idle cycle between bytes, 2: random gaps
   task automatic run_frame(input string tag, input int mode);
      bit gap;
      do_start();
      for (int i = 0; i < frame_q.size(); i++) begin
         gap = (mode == 1) ? (i > 0) : (mode == 2) ? ($urandom_range(0, 2) == 0) : 1'b0;
         send_byte(frame_q[i], gap);
      end
      @(negedge clk);
      in_valid = 1'b0;
      @(negedge clk);
      check_model(tag);
   endtask

   task automatic build_frame(input int unsigned n, input bit bad);
      logic [7:0] x;
      logic [7:0] b;
      frame_q.delete();
      frame_q.push_back(n[7:0]);
      frame_q.push_back(n[15:8]);
      if (n <= 2048) begin
         for (int i = 0; i < 3 * int'(n); i++) begin
            b = 8'($urandom);
            frame_q.push_back(b);
         end
         x = 8'h00;
         foreach (frame_q[i]) x ^= frame_q[i];
         if (bad) x ^= 8'(1 << $urandom_range(0, 7));
         frame_q.push_back(x);
      end
   endtask

   initial begin
      int unsigned n;
      int          kind;
      repeat (3) @(negedge clk);
      check("rst_in_ready", in_ready, 0);
      check("rst_wr_en", mem_wr_en, 0);
      check("rst_addr", mem_addr, 0);
      check("rst_data", mem_data, 0);
      check("rst_busy", busy, 0);
      check("rst_done", done, 0);
      check("rst_error", error, 0);
      check("rst_words", words_loaded, 0);
      rst = 1'b0;

      frame_q = '{8'h02, 8'h00, 8'h00, 8'h80, 8'h00, 8'h03, 8'h50, 8'h00, 8'hD1};
      run_frame("two_word", 0);
      check("two_word_d0", seen_q.size() > 0 ? seen_q[0].d : 17'h0, 17'h08000);
      check("two_word_d1", seen_q.size() > 1 ? seen_q[1].d : 17'h0, 17'h05003);

      frame_q = '{8'h02, 8'h00, 8'h00, 8'h80, 8'h00, 8'h03, 8'h50, 8'h00, 8'hD0};
      run_frame("bad_chk", 0);
      check("bad_chk_err", error, 1);

      frame_q = '{8'h01, 8'h00, 8'hFF, 8'hFF, 8'hFF, 8'hFE};
      run_frame("upper", 0);
      check("upper_d0", seen_q.size() > 0 ? seen_q[0].d : 17'h0, 17'h1FFFF);

      frame_q = '{8'h01, 8'h08};
      run_frame("overflow", 0);
      check("overflow_err", error, 1);

      frame_q = '{8'h00, 8'h00, 8'h00};
      run_frame("zero_len", 0);

      frame_q = '{8'h02, 8'h00, 8'h00, 8'h80, 8'h00, 8'h03, 8'h50, 8'h00, 8'hD1};
      run_frame("toggle", 1);

      // Reset after the 4th data byte: only word 0 may have been written.
      do_start();
      for (int i = 0; i < 6; i++) send_byte(frame_q[i], 1'b0);
      @(negedge clk);
      in_valid = 1'b0;
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      check("midrst_in_ready", in_ready, 0);
      check("midrst_wr_en", mem_wr_en, 0);
      check("midrst_addr", mem_addr, 0);
      check("midrst_data", mem_data, 0);
      check("midrst_busy", busy, 0);
      check("midrst_done", done, 0);
      check("midrst_error", error, 0);
      check("midrst_words", words_loaded, 0);
      repeat (4) @(negedge clk);
      check("midrst_nwrites", seen_q.size(), 1);
      check("midrst_d0", seen_q.size() > 0 ? seen_q[0].d : 17'h0, 17'h08000);
      run_frame("after_rst", 0);

      for (int t = 0; t < 30; t++) begin
         kind = $urandom_range(0, 7);
         if (kind == 0) n = $urandom_range(2049, 65535);
         else if (kind == 1) n = 0;
         else n = $urandom_range(1, 8);
         build_frame(n, $urandom_range(0, 3) == 0);
         run_frame("rand", $urandom_range(0, 2));
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
